bl_mask_burst_seq: RTL and testbench

- Registered, burst-capable bitline-mask sequencer for the configurable-width SRAM column path.
- Accepts one access request: start sub-word address, width config and beat count. Emits one bitline mask per beat over a valid/ready stream to the column drivers / sense-amp enables.
- Generalises the fixed 8/32 combinational mask decode to any BL_WIDTH/MIN_WORD ratio.
- Adds multi-beat sequencing, row-advance signalling and config error reporting.

---
 rtl/bl_mask_pkg.sv | 13 +
 rtl/bl_mask_if.sv | 36 +++
 rtl/bl_mask_burst_seq_decode.sv | 30 +++
 rtl/bl_mask_burst_seq.sv | 85 ++++++++
 tb/tb_bl_mask_burst_seq.sv | 129 ++++++++++++
 5 files changed

// File: rtl/bl_mask_pkg.sv
// bl_mask_pkg: shared defaults, derived widths, sequencer state type and word-width helper
package bl_mask_pkg;
  localparam int DEF_BL_WIDTH = 32;
  localparam int DEF_MIN_WORD = 8;
  localparam int DEF_LEN_W = 4;
  localparam int DEF_ADDR_W = $clog2(DEF_BL_WIDTH / DEF_MIN_WORD);
  localparam int DEF_CONF_W = $clog2(DEF_ADDR_W + 1);
  localparam int DEF_MAX_CONF = DEF_ADDR_W;
  typedef enum logic {IDLE, BURST} state_t;
  function automatic int word_w(input int bl, input int k);
    return bl >> k;
  endfunction
endpackage

// File: rtl/bl_mask_if.sv
// bl_mask_if: request stream in, bitline-mask beat stream out; slave = sequencer, master = requester/consumer
// Signals: req_valid/req_ready/req_addr/req_conf/req_len[/req_gmask], mask_valid/mask_ready/bl_mask/mask_idx/mask_last/mask_row_inc, cfg_err
// Optional req_gmask exists only with BL_MASK_GRAN_WMASK_EN defined
interface bl_mask_if #(
  parameter int BL_WIDTH = bl_mask_pkg::DEF_BL_WIDTH,
  parameter int MIN_WORD = bl_mask_pkg::DEF_MIN_WORD,
  parameter int LEN_W = bl_mask_pkg::DEF_LEN_W
);
  localparam int ADDR_W = $clog2(BL_WIDTH / MIN_WORD);
  localparam int CONF_W = $clog2(ADDR_W + 1);
  localparam int G = BL_WIDTH / MIN_WORD;
  logic req_valid, req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic [CONF_W-1:0] req_conf;
  logic [LEN_W-1:0] req_len;
`ifdef BL_MASK_GRAN_WMASK_EN
  logic [G-1:0] req_gmask;
`endif
  logic mask_valid, mask_ready, mask_last, mask_row_inc, cfg_err;
  logic [BL_WIDTH-1:0] bl_mask;
  logic [ADDR_W-1:0] mask_idx;
  modport master(
`ifdef BL_MASK_GRAN_WMASK_EN
    output req_gmask,
`endif
    output req_valid, req_addr, req_conf, req_len, mask_ready,
    input req_ready, mask_valid, bl_mask, mask_idx, mask_last, mask_row_inc, cfg_err
  );
  modport slave(
`ifdef BL_MASK_GRAN_WMASK_EN
    input req_gmask,
`endif
    input req_valid, req_addr, req_conf, req_len, mask_ready,
    output req_ready, mask_valid, bl_mask, mask_idx, mask_last, mask_row_inc, cfg_err
  );
endinterface

// File: rtl/bl_mask_burst_seq_decode.sv
// bl_mask_decode: combinational (idx, k[, gmask]) -> bitline mask with ones at [idx*W +: W], W = BL_WIDTH>>k
// Ports: idx (sub-word index), k (width config, assumed legal), gmask (granule enables, BL_MASK_GRAN_WMASK_EN only), mask (out)
module bl_mask_decode import bl_mask_pkg::*; #(
  parameter int BL_WIDTH = DEF_BL_WIDTH,
  parameter int MIN_WORD = DEF_MIN_WORD,
  localparam int ADDR_W = $clog2(BL_WIDTH / MIN_WORD),
  localparam int CONF_W = $clog2(ADDR_W + 1),
  localparam int G = BL_WIDTH / MIN_WORD,
  localparam int GW = $clog2(G)
) (
  input logic [ADDR_W-1:0] idx,
  input logic [CONF_W-1:0] k,
`ifdef BL_MASK_GRAN_WMASK_EN
  input logic [G-1:0] gmask,
`endif
  output logic [BL_WIDTH-1:0] mask
);
  int w, base;
  always_comb begin
    w = word_w(BL_WIDTH, int'(k));
    base = int'(idx) * w;
    mask = '0;
    for (int b = 0; b < BL_WIDTH; b++)
`ifdef BL_MASK_GRAN_WMASK_EN
      mask[b] = b >= base && b < base + w && gmask[GW'((b - base) / MIN_WORD)];
`else
      mask[b] = b >= base && b < base + w;
`endif
  end
endmodule

// File: rtl/bl_mask_burst_seq.sv
// bl_mask_burst_seq: registered burst sequencer emitting one bitline mask per beat for the SRAM column path
// Ports: clk, rst_n (async active-low), bus (bl_mask_if.slave: request in, mask beats out, cfg_err pulse)
// Option: BL_MASK_GRAN_WMASK_EN adds per-granule write mask req_gmask, latched per burst
module bl_mask_burst_seq import bl_mask_pkg::*; #(
  parameter int BL_WIDTH = DEF_BL_WIDTH,
  parameter int MIN_WORD = DEF_MIN_WORD,
  parameter int LEN_W = DEF_LEN_W
) (
  input logic clk,
  input logic rst_n,
  bl_mask_if.slave bus
);
  localparam int ADDR_W = $clog2(BL_WIDTH / MIN_WORD);
  localparam int CONF_W = $clog2(ADDR_W + 1);
  localparam int MAX_CONF = ADDR_W;
  localparam int G = BL_WIDTH / MIN_WORD;
  state_t state;
  logic [CONF_W-1:0] k_q, nk;
  logic [LEN_W-1:0] cnt;
  logic [ADDR_W-1:0] nidx, amask;
  logic [BL_WIDTH-1:0] nmask;
  logic adv, acc, legal, ld;
`ifdef BL_MASK_GRAN_WMASK_EN
  logic [G-1:0] gmask_q, ngmask;
  assign ngmask = ld ? bus.req_gmask : gmask_q;
`endif
  assign adv = bus.mask_valid && bus.mask_ready;
  assign bus.req_ready = rst_n && (state == IDLE || (adv && bus.mask_last));
  assign acc = bus.req_valid && bus.req_ready;
  assign legal = bus.req_conf <= CONF_W'(MAX_CONF);
  assign ld = acc && legal;
  // nidx/nk describe whichever beat is shown next: a fresh beat 0 or the successor of the current beat
  assign nk = ld ? bus.req_conf : k_q;
  assign amask = ADDR_W'((1 << nk) - 1);
  assign nidx = (ld ? bus.req_addr : bus.mask_idx + 1'b1) & amask;
  bl_mask_decode #(.BL_WIDTH(BL_WIDTH), .MIN_WORD(MIN_WORD)) u_dec (
    .idx(nidx),
    .k(nk),
`ifdef BL_MASK_GRAN_WMASK_EN
    .gmask(ngmask),
`endif
    .mask(nmask)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      k_q <= '0;
      cnt <= '0;
`ifdef BL_MASK_GRAN_WMASK_EN
      gmask_q <= '0;
`endif
      bus.mask_valid <= 1'b0;
      bus.bl_mask <= '0;
      bus.mask_idx <= '0;
      bus.mask_last <= 1'b0;
      bus.mask_row_inc <= 1'b0;
      bus.cfg_err <= 1'b0;
    end else begin
      bus.cfg_err <= acc && !legal;
      if (ld) begin
        state <= BURST;
        k_q <= bus.req_conf;
        cnt <= bus.req_len;
`ifdef BL_MASK_GRAN_WMASK_EN
        gmask_q <= bus.req_gmask;
`endif
        bus.mask_valid <= 1'b1;
        bus.bl_mask <= nmask;
        bus.mask_idx <= nidx;
        bus.mask_last <= bus.req_len == '0;
        bus.mask_row_inc <= nidx == amask;
      end else if (adv && bus.mask_last) begin
        state <= IDLE;
        bus.mask_valid <= 1'b0;
        bus.mask_last <= 1'b0;
        bus.mask_row_inc <= 1'b0;
      end else if (adv) begin
        cnt <= cnt - 1'b1;
        bus.bl_mask <= nmask;
        bus.mask_idx <= nidx;
        bus.mask_last <= cnt == LEN_W'(1);
        bus.mask_row_inc <= nidx == amask;
      end
    end
endmodule

// File: tb/tb_bl_mask_burst_seq.sv
// tb_bl_mask_burst_seq: directed plus random stimulus against a beat-queue reference model
module tb_bl_mask_burst_seq;
  typedef struct {logic [31:0] m; logic [1:0] idx; bit last; bit row;} beat_t;
  logic clk = 0, rst_n = 0;
  int n_chk = 0, n_fail = 0;
  beat_t q[$];
  bit exp_err = 0;
  bl_mask_if #(.BL_WIDTH(32), .MIN_WORD(8), .LEN_W(4)) bus();
  bl_mask_burst_seq #(.BL_WIDTH(32), .MIN_WORD(8), .LEN_W(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic [31:0] ref_mask(input int idx, input int k, input logic [3:0] gm);
    int w = 32 >> k;
    logic [31:0] m = 0;
    for (int j = 0; j < w / 8; j++)
      if (gm[j]) m |= 32'hFF << (idx * w + j * 8);
    return m;
  endfunction
  task automatic idle_inputs();
    bus.req_valid = 0;
    bus.req_addr = 0;
    bus.req_conf = 0;
    bus.req_len = 0;
    bus.mask_ready = 0;
`ifdef BL_MASK_GRAN_WMASK_EN
    bus.req_gmask = 0;
`endif
  endtask
  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    rst_n = 0;
    #1;
    chk("rst_valid", bus.mask_valid, 0);
    chk("rst_mask", bus.bl_mask, 0);
    chk("rst_idx", bus.mask_idx, 0);
    chk("rst_last", bus.mask_last, 0);
    chk("rst_row", bus.mask_row_inc, 0);
    chk("rst_err", bus.cfg_err, 0);
    chk("rst_ready", bus.req_ready, 0);
    q.delete();
    exp_err = 0;
    @(negedge clk);
    rst_n = 1;
  endtask
  task automatic step(input bit rv, input logic [1:0] a, input logic [1:0] c, input logic [3:0] l,
                      input bit mr, input logic [3:0] gm);
    bit rdy;
    logic [3:0] gmx;
    @(negedge clk);
    chk("valid", bus.mask_valid, q.size() != 0);
    chk("cfg_err", bus.cfg_err, exp_err);
    if (q.size() != 0) begin
      chk("bl_mask", bus.bl_mask, q[0].m);
      chk("idx", bus.mask_idx, q[0].idx);
      chk("last", bus.mask_last, q[0].last);
      chk("row_inc", bus.mask_row_inc, q[0].row);
    end
    bus.req_valid = rv;
    bus.req_addr = a;
    bus.req_conf = c;
    bus.req_len = l;
    bus.mask_ready = mr;
`ifdef BL_MASK_GRAN_WMASK_EN
    bus.req_gmask = gm;
    gmx = gm;
`else
    gmx = 4'hF;
`endif
    #1;
    rdy = q.size() == 0 || (mr && q.size() == 1);
    chk("req_ready", bus.req_ready, rdy);
    exp_err = rv && rdy && c > 2;
    if (mr && q.size() != 0) void'(q.pop_front());
    if (rv && rdy && c <= 2)
      for (int i = 0; i <= int'(l); i++) begin
        int n = 1 << c;
        int id = (int'(a) % n + i) % n;
        beat_t b;
        b.m = ref_mask(id, int'(c), gmx);
        b.idx = 2'(id);
        b.last = i == int'(l);
        b.row = id == n - 1;
        q.push_back(b);
      end
  endtask
  initial begin
    idle_inputs();
    do_reset();
    step(1, 0, 2, 7, 1, 4'hF);
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0);
    do_reset();
    step(1, 3, 0, 0, 1, 4'hF);
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1, 0);
    step(1, 2, 2, 3, 1, 4'hF);
    repeat (5) step(0, 0, 0, 0, 1, 0);
    step(1, 1, 1, 1, 0, 4'hF);
    repeat (3) step(0, 0, 0, 0, 0, 0);
    repeat (3) step(0, 0, 0, 0, 1, 0);
    step(1, 1, 2, 1, 1, 4'hF);
    step(0, 0, 0, 0, 1, 0);
    step(1, 0, 1, 0, 1, 4'hF);
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1, 0);
    step(1, 0, 3, 2, 1, 4'hF);
    repeat (3) step(0, 0, 0, 0, 1, 0);
`ifdef BL_MASK_GRAN_WMASK_EN
    step(1, 0, 1, 0, 1, 4'b0110);
    step(0, 0, 0, 0, 1, 0);
    chk("gmask_fixed", bus.bl_mask, 32'h0000_FF00);
    step(0, 0, 0, 0, 1, 0);
`endif
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 299) == 0) do_reset();
      step($urandom_range(0, 1) == 1, 2'($urandom), 2'($urandom), 4'($urandom),
           $urandom_range(0, 9) < 7, 4'($urandom));
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
    $finish;
  end
endmodule
